alu_sequencer: RTL and testbench
================================

# alu_sequencer

Single-request controller that drives the ALU block control lines (`outctl`, `loadctl`, `arg_l`, `arg_r`, `alt`, `calcfn`, `cin`). Accepts one register-to-register ALU operation per handshake and expands it into one execute cycle, or two for 16-bit register-pair operations with carry chained through the flags register. Sits between instruction decode and the ALU block.

## Interface
- `CARRY_BIT`, 0, index of the carry flag within `fout`
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept; high only in IDLE
- `req_op`  in  4  operation code (see Operation)
- `req_wide`  in  1  16-bit pair operation
- `req_dst`, `req_src_l`, `req_src_r`  in  2 each  register index 0=A 1=B 2=C 3=D
- `fout`  in  4  flags from ALU block
- `outctl`, `loadctl`  out  4 each  ALU block bus-driver / load selects
- `arg_l`  out  2; `arg_r`  out  3  ALU operand selects
- `alt`, `cin`  out  1 each  function modifier, carry-in
- `calcfn`  out  1  active-low flag-calculate strobe
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse after last execute cycle
- `err`  out  1  one-cycle pulse on rejected request

## Operation
- Register codes on `outctl`/`loadctl`: A=4'h0, B=4'h1, C=4'h8, D=4'h9. Unit codes on `outctl`: addsub=4'h2, andor=4'h6, shiftswap=4'h7, xornot=4'hA. Idle code for both = 4'hF. Idle `arg_l`=0, `arg_r`=3'b100 (no register), `calcfn`=1, `alt`=0, `cin`=0.
- Ops (`outctl` unit, `alt`, `cin`, writes dst, sets flags):
  - 0 ADD: addsub, 0, 0, yes, yes. 1 ADC: addsub, 0, carry, yes, yes
  - 2 SUB: addsub, 1, 1, yes, yes. 3 SBC: addsub, 1, carry, yes, yes
  - 4 AND: andor,0. 5 OR: andor,1. 6 XOR: xornot,0. 7 NOT: xornot,1 (`arg_r`=3'b100). All cin 0, write, flags.
  - 8 SHL: shiftswap,0,cin 0. 9 RLC: shiftswap,0,cin=carry. A SWAP: shiftswap,1,cin 0. All `arg_r`=3'b100, write, flags.
  - B MOV: `outctl`=code of src_l, `loadctl`=dst, `calcfn`=1.
  - C CMP: as SUB but `loadctl`=4'hF.
  - D–F: illegal.
- "carry" = `fout[CARRY_BIT]` sampled in the execute cycle it is driven in.
- Execute cycle: `arg_l`=src_l, `arg_r`={1'b0,src_r}, `loadctl`=dst code unless none, `calcfn`=0 if op sets flags.
- Wide: legal only for ADD, ADC, SUB, SBC, MOV, CMP. EXEC_LO uses given indices; EXEC_HI uses each index XOR 1 (A↔B, C↔D) and `cin`=carry for all arithmetic ops (flags from EXEC_LO already latched). Wide MOV: two plain moves.
- FSM: IDLE → (valid & legal) EXEC_LO → (wide) EXEC_HI → DONE → IDLE. IDLE → (valid & illegal) ERR → IDLE. DONE/ERR states output idle codes and pulse `done`/`err`.
- Request fields captured at acceptance; inputs ignored while busy.

## Timing
- Accept on edge where `req_valid & req_ready`; all control outputs are registered.
- Narrow: EXEC_LO controls valid in cycle N+1; `done` in N+2; `req_ready` high again in N+3. Throughput one op per 3 cycles.
- Wide: EXEC_LO N+1, EXEC_HI N+2, `done` N+3, ready N+4.
- Illegal: `err` in N+1, no control output leaves idle codes, ready N+2.
- Reset: all outputs idle codes, `req_ready`=1, `busy`=`done`=`err`=0 on the edge `rst` is sampled high; mid-operation reset abandons the op with no `done`, no partial EXEC_HI.
- No `outctl` code other than idle or the single selected driver ever appears, so the bus has at most one driver every cycle.

## Test plan
- ADD A←B+C: op 0, dst 0, src_l 1, src_r 2 → N+1: outctl 4'h2, loadctl 4'h0, arg_l 1, arg_r 2, alt 0, cin 0, calcfn 0; `done` N+2.
- Wide SBC C:D←A:B−C:D with fout carry 0 then 1 → EXEC_LO alt 1 cin 0 arg_l 0 arg_r 2 loadctl 4'h8; EXEC_HI arg_l 1 arg_r 3 loadctl 4'h9 cin 1; `done` N+3.
- CMP and MOV D←A → CMP loadctl 4'hF calcfn 0; MOV outctl 4'h0 loadctl 4'h9 calcfn 1.
- Illegal op 4'hE, and wide AND → `err` pulse N+1, outputs stay idle, no `done`.
- Back-to-back `req_valid` held high → `req_ready` low N+1..N+2, second op accepted N+3.
- `rst` asserted during EXEC_LO of wide op → next cycle idle codes, `req_ready` 1, no EXEC_HI, no `done`.

Source files
------------

// File: rtl/alu_sequencer.sv
// Sequences one register-to-register ALU operation per handshake into one or two
// execute cycles of ALU block control lines; 16-bit pair ops chain carry via fout.
module alu_sequencer #(
    parameter int CARRY_BIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_op,
    input  logic       req_wide,
    input  logic [1:0] req_dst,
    input  logic [1:0] req_src_l,
    input  logic [1:0] req_src_r,
    input  logic [3:0] fout,
    output logic [3:0] outctl,
    output logic [3:0] loadctl,
    output logic [1:0] arg_l,
    output logic [2:0] arg_r,
    output logic       alt,
    output logic       cin,
    output logic       calcfn,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC_LO, S_EXEC_HI, S_DONE, S_ERR} state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       wide_q, wide_d;
    logic [1:0] dst_q, dst_d, src_l_q, src_l_d, src_r_q, src_r_d;
    logic [3:0] outctl_q, outctl_d, loadctl_q, loadctl_d;
    logic [1:0] arg_l_q, arg_l_d;
    logic [2:0] arg_r_q, arg_r_d;
    logic       alt_q, alt_d, calcfn_q, calcfn_d;
    logic       cin_carry_q, cin_carry_d, cin_fix_q, cin_fix_d;
    logic       ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic [3:0] s_op;
    logic [1:0] s_dst, s_l, s_r;
    logic       hi, legal;

    function automatic logic [3:0] reg_code(input logic [1:0] idx);
        return {idx[1], 2'b00, idx[0]};
    endfunction

    always_comb begin
        legal = (req_op <= 4'hC) &&
                (!req_wide || req_op <= 4'h3 || req_op == 4'hB || req_op == 4'hC);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wide_d  = wide_q;
        dst_d   = dst_q;
        src_l_d = src_l_q;
        src_r_d = src_r_q;
        hi      = 1'b0;
        s_op    = op_q;
        s_dst   = dst_q;
        s_l     = src_l_q;
        s_r     = src_r_q;
        case (state_q)
            S_IDLE: begin
                s_op  = req_op;
                s_dst = req_dst;
                s_l   = req_src_l;
                s_r   = req_src_r;
                if (req_valid) begin
                    if (legal) begin
                        state_d = S_EXEC_LO;
                        op_d    = req_op;
                        wide_d  = req_wide;
                        dst_d   = req_dst;
                        src_l_d = req_src_l;
                        src_r_d = req_src_r;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_EXEC_LO: begin
                state_d = wide_q ? S_EXEC_HI : S_DONE;
                // high half of a register pair is the partner register (A<->B, C<->D)
                hi    = 1'b1;
                s_dst = dst_q ^ 2'b01;
                s_l   = src_l_q ^ 2'b01;
                s_r   = src_r_q ^ 2'b01;
            end
            S_EXEC_HI: state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase

        outctl_d    = 4'hF;
        loadctl_d   = 4'hF;
        arg_l_d     = 2'd0;
        arg_r_d     = 3'b100;
        alt_d       = 1'b0;
        calcfn_d    = 1'b1;
        cin_carry_d = 1'b0;
        cin_fix_d   = 1'b0;
        if (state_d == S_EXEC_LO || state_d == S_EXEC_HI) begin
            arg_l_d   = s_l;
            arg_r_d   = {1'b0, s_r};
            loadctl_d = reg_code(s_dst);
            calcfn_d  = 1'b0;
            case (s_op)
                4'h0, 4'h1, 4'h2, 4'h3, 4'hC: begin
                    outctl_d    = 4'h2;
                    alt_d       = s_op[1] | (s_op == 4'hC);
                    cin_carry_d = hi | (s_op == 4'h1) | (s_op == 4'h3);
                    cin_fix_d   = alt_d;
                    if (s_op == 4'hC) loadctl_d = 4'hF;
                end
                4'h4: outctl_d = 4'h6;
                4'h5: begin outctl_d = 4'h6; alt_d = 1'b1; end
                4'h6: outctl_d = 4'hA;
                4'h7: begin outctl_d = 4'hA; alt_d = 1'b1; arg_r_d = 3'b100; end
                4'h8: begin outctl_d = 4'h7; arg_r_d = 3'b100; end
                4'h9: begin outctl_d = 4'h7; arg_r_d = 3'b100; cin_carry_d = 1'b1; end
                4'hA: begin outctl_d = 4'h7; arg_r_d = 3'b100; alt_d = 1'b1; end
                4'hB: begin outctl_d = reg_code(s_l); calcfn_d = 1'b1; end
                default: ;
            endcase
        end
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 4'h0;
            wide_q      <= 1'b0;
            dst_q       <= 2'd0;
            src_l_q     <= 2'd0;
            src_r_q     <= 2'd0;
            outctl_q    <= 4'hF;
            loadctl_q   <= 4'hF;
            arg_l_q     <= 2'd0;
            arg_r_q     <= 3'b100;
            alt_q       <= 1'b0;
            calcfn_q    <= 1'b1;
            cin_carry_q <= 1'b0;
            cin_fix_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            wide_q      <= wide_d;
            dst_q       <= dst_d;
            src_l_q     <= src_l_d;
            src_r_q     <= src_r_d;
            outctl_q    <= outctl_d;
            loadctl_q   <= loadctl_d;
            arg_l_q     <= arg_l_d;
            arg_r_q     <= arg_r_d;
            alt_q       <= alt_d;
            calcfn_q    <= calcfn_d;
            cin_carry_q <= cin_carry_d;
            cin_fix_q   <= cin_fix_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // carry-in follows the live flags during the execute cycle it is used in
    assign cin       = cin_carry_q ? fout[CARRY_BIT] : cin_fix_q;
    assign outctl    = outctl_q;
    assign loadctl   = loadctl_q;
    assign arg_l     = arg_l_q;
    assign arg_r     = arg_r_q;
    assign alt       = alt_q;
    assign calcfn    = calcfn_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected control cycles are queued at request
// time from an opcode table model and compared cycle by cycle on the falling edge.
module tb_alu_sequencer;
    localparam int CB = 0;

    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, req_wide;
    logic [3:0] req_op, fout, outctl, loadctl;
    logic [1:0] req_dst, req_src_l, req_src_r, arg_l;
    logic [2:0] arg_r;
    logic       alt, cin, calcfn, busy, done, err;

    alu_sequencer #(.CARRY_BIT(CB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wide(req_wide), .req_dst(req_dst),
        .req_src_l(req_src_l), .req_src_r(req_src_r), .fout(fout),
        .outctl(outctl), .loadctl(loadctl), .arg_l(arg_l), .arg_r(arg_r),
        .alt(alt), .cin(cin), .calcfn(calcfn), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] outctl, loadctl;
        logic [1:0] arg_l;
        logic [2:0] arg_r;
        logic       alt, cin, calcfn, done, err, ready, busy;
    } ctl_t;

    typedef struct {
        ctl_t       exp;
        logic [3:0] f;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ctl_t idle_ctl();
        ctl_t c;
        c = '0;
        c.outctl = 4'hF; c.loadctl = 4'hF; c.arg_r = 3'b100; c.calcfn = 1'b1; c.ready = 1'b1;
        return c;
    endfunction

    function automatic logic [3:0] rcode(input logic [1:0] i);
        case (i)
            2'd0: return 4'h0;
            2'd1: return 4'h1;
            2'd2: return 4'h8;
            default: return 4'h9;
        endcase
    endfunction

    function automatic ctl_t model(input logic [3:0] op, input logic [1:0] dst, sl, sr,
                                   input bit hi, input logic c);
        ctl_t       e;
        logic [1:0] d, l, r;
        d = hi ? {dst[1], ~dst[0]} : dst;
        l = hi ? {sl[1], ~sl[0]} : sl;
        r = hi ? {sr[1], ~sr[0]} : sr;
        e = idle_ctl();
        e.ready = 1'b0; e.busy = 1'b1;
        e.arg_l = l; e.arg_r = {1'b0, r}; e.loadctl = rcode(d); e.calcfn = 1'b0;
        case (op)
            4'h0: begin e.outctl = 4'h2; e.cin = hi ? c : 1'b0; end
            4'h1: begin e.outctl = 4'h2; e.cin = c; end
            4'h2: begin e.outctl = 4'h2; e.alt = 1'b1; e.cin = hi ? c : 1'b1; end
            4'h3: begin e.outctl = 4'h2; e.alt = 1'b1; e.cin = c; end
            4'h4: e.outctl = 4'h6;
            4'h5: begin e.outctl = 4'h6; e.alt = 1'b1; end
            4'h6: e.outctl = 4'hA;
            4'h7: begin e.outctl = 4'hA; e.alt = 1'b1; e.arg_r = 3'b100; end
            4'h8: begin e.outctl = 4'h7; e.arg_r = 3'b100; end
            4'h9: begin e.outctl = 4'h7; e.arg_r = 3'b100; e.cin = c; end
            4'hA: begin e.outctl = 4'h7; e.alt = 1'b1; e.arg_r = 3'b100; end
            4'hB: begin e.outctl = rcode(l); e.calcfn = 1'b1; end
            default: begin
                e.outctl = 4'h2; e.alt = 1'b1; e.cin = hi ? c : 1'b1; e.loadctl = 4'hF;
            end
        endcase
        return e;
    endfunction

    function automatic ctl_t observe();
        ctl_t o;
        o.outctl = outctl; o.loadctl = loadctl; o.arg_l = arg_l; o.arg_r = arg_r;
        o.alt = alt; o.cin = cin; o.calcfn = calcfn; o.done = done; o.err = err;
        o.ready = req_ready; o.busy = busy;
        return o;
    endfunction

    task automatic compare(input string tag, input ctl_t o, input ctl_t e);
        check({tag, ".outctl"},  8'(o.outctl),  8'(e.outctl));
        check({tag, ".loadctl"}, 8'(o.loadctl), 8'(e.loadctl));
        check({tag, ".arg_l"},   8'(o.arg_l),   8'(e.arg_l));
        check({tag, ".arg_r"},   8'(o.arg_r),   8'(e.arg_r));
        check({tag, ".alt"},     8'(o.alt),     8'(e.alt));
        check({tag, ".cin"},     8'(o.cin),     8'(e.cin));
        check({tag, ".calcfn"},  8'(o.calcfn),  8'(e.calcfn));
        check({tag, ".done"},    8'(o.done),    8'(e.done));
        check({tag, ".err"},     8'(o.err),     8'(e.err));
        check({tag, ".ready"},   8'(o.ready),   8'(e.ready));
        check({tag, ".busy"},    8'(o.busy),    8'(e.busy));
    endtask

    function automatic logic [3:0] flags(input logic c);
        logic [3:0] f;
        f = 4'($urandom);
        f[CB] = c;
        return f;
    endfunction

    function automatic bit is_legal(input logic [3:0] op, input logic wide);
        if (op >= 4'hD) return 1'b0;
        if (wide && op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA}) return 1'b0;
        return 1'b1;
    endfunction

    // keep: hold req_valid high with junk fields while busy; chained: already at the
    // falling edge where the previous op's ready cycle was checked, drive immediately
    task automatic run_op(input string tag, input logic [3:0] op, input logic wide,
                          input logic [1:0] dst, sl, sr, input logic c_lo, c_hi,
                          input bit keep, input bit chained);
        ent_t e;
        if (!chained) @(negedge clk);
        req_valid = 1'b1; req_op = op; req_wide = wide;
        req_dst = dst; req_src_l = sl; req_src_r = sr;
        @(posedge clk);
        #1;
        if (keep) begin
            req_op = 4'($urandom); req_wide = 1'($urandom);
            req_dst = 2'($urandom); req_src_l = 2'($urandom); req_src_r = 2'($urandom);
        end else begin
            req_valid = 1'b0;
        end
        if (!is_legal(op, wide)) begin
            e.exp = idle_ctl(); e.exp.ready = 1'b0; e.exp.busy = 1'b1; e.exp.err = 1'b1;
            e.f = flags(1'b1); sb.push_back(e);
        end else begin
            e.exp = model(op, dst, sl, sr, 1'b0, c_lo); e.f = flags(c_lo); sb.push_back(e);
            if (wide) begin
                e.exp = model(op, dst, sl, sr, 1'b1, c_hi); e.f = flags(c_hi); sb.push_back(e);
            end
            e.exp = idle_ctl(); e.exp.ready = 1'b0; e.exp.busy = 1'b1; e.exp.done = 1'b1;
            e.f = flags(1'b1); sb.push_back(e);
        end
        e.exp = idle_ctl(); e.f = flags(1'b1); sb.push_back(e);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            fout = e.f;
            @(negedge clk);
            compare(tag, observe(), e.exp);
            if (sb.size() > 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        ctl_t e;
        rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_wide = 1'b0;
        req_dst = 2'd0; req_src_l = 2'd0; req_src_r = 2'd0; fout = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare("reset", observe(), idle_ctl());
        rst = 1'b0;

        run_op("add",      4'h0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("wide_sbc", 4'h3, 1'b1, 2'd2, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op("cmp",      4'hC, 1'b0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("mov",      4'hB, 1'b0, 2'd3, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("illegal",  4'hE, 1'b0, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("wide_and", 4'h4, 1'b1, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("adc",      4'h1, 1'b0, 2'd3, 2'd3, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("not",      4'h7, 1'b0, 2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("rlc",      4'h9, 1'b0, 2'd1, 2'd3, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("swap",     4'hA, 1'b0, 2'd0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("wide_sub", 4'h2, 1'b1, 2'd0, 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("wide_mov", 4'hB, 1'b1, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        run_op("wide_cmp", 4'hC, 1'b1, 2'd3, 2'd1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

        run_op("b2b_first",  4'h5, 1'b0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("b2b_second", 4'h8, 1'b0, 2'd1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        // reset during EXEC_LO of a wide op
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'h0; req_wide = 1'b1;
        req_dst = 2'd2; req_src_l = 2'd0; req_src_r = 2'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0; fout = flags(1'b0);
        @(negedge clk);
        compare("rst_lo", observe(), model(4'h0, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        compare("rst_hit", observe(), idle_ctl());
        rst = 1'b0;
        fout = flags(1'b1);
        repeat (2) begin
            @(negedge clk);
            compare("rst_after", observe(), idle_ctl());
        end

        for (int i = 0; i < 25; i++) begin
            run_op("rand", 4'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                   2'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
